opc5_uart: RTL and testbench

- Memory-mapped serial port on the opc5 CPU bus, directly downstream of the CPU next to the main memory.
- Consumes the CPU's address/rnw/write-data cycles and returns read data for the top level to drive onto the shared tristate data bus.
- Provides an 8N1 transmitter with a small TX FIFO, a single-byte receiver, and a programmable baud divisor.
- Used so test programs can emit characters instead of relying only on memory dumps.

---
 rtl/opc5_uart_pkg.sv | 33 +++
 rtl/opc5_uart_fifo.sv | 52 +++++
 rtl/opc5_uart.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_opc5_uart.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opc5_uart_pkg.sv
// Shared constants and FSM state types for the opc5 memory-mapped UART.
package opc5_uart_pkg;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFE00;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_RX_VALID     = 0;
    localparam int ST_RX_OVERRUN   = 1;
    localparam int ST_RX_FRAME_ERR = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_TX_EMPTY     = 4;
    localparam int ST_TX_BUSY      = 5;
    localparam int ST_TX_IE        = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/opc5_uart_fifo.sv
// Small synchronous FIFO for the UART transmitter; pointers carry an extra wrap bit.
module opc5_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Fullness is judged on pre-edge state, so a push while full is dropped
    // even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign dout_o   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/opc5_uart.sv
// opc5 bus UART: 8N1 transmitter behind a small FIFO, single-byte receiver,
// programmable baud divisor. Bus handshake: a strobe is any clock with sel high.
module opc5_uart
    import opc5_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] RESET_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        rnw,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdata_oe,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);

    logic sel, wr_stb, rd_stb;
    logic wr_data, wr_status, wr_div, rd_data;

    assign sel       = (address[15:2] == BASE_ADDR[15:2]);
    assign wr_stb    = sel && !rnw;
    assign rd_stb    = sel && rnw;
    assign wr_data   = wr_stb && (address[1:0] == REG_DATA);
    assign wr_status = wr_stb && (address[1:0] == REG_STATUS);
    assign wr_div    = wr_stb && (address[1:0] == REG_DIV);
    assign rd_data   = rd_stb && (address[1:0] == REG_DATA);

    logic [15:0] div_q, div_d;
    logic        tx_ie_q, tx_ie_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        rx_frame_err_q, rx_frame_err_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        irq_q, irq_d;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    opc5_uart_fifo #(
        .WIDTH(8),
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (wr_data),
        .pop_i   (fifo_pop),
        .din_i   (wdata[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Transmitter. The divisor is latched at each bit boundary so DIV writes
    // never stretch or truncate the bit in flight.
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_bit_end, tx_empty;

    assign tx_bit_end = (tx_cnt_q >= tx_div_q);
    assign tx_empty   = fifo_empty && (tx_state_q == TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? tx_cnt_q : tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d    = 1'b1;
                tx_cnt_d = 16'd0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_dout;
                    tx_div_d   = div_q;
                    txd_d      = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = 16'd0;
                    tx_div_d   = div_q;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = 16'd0;
                    tx_div_d = div_q;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d = 16'd0;
                    tx_div_d = div_q;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_shift_d = fifo_dout;
                        txd_d      = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end
            end
        endcase
    end

    // Receiver: 2-flop synchroniser, then a falling-edge detector on the clean line.
    rx_state_e   rx_state_q, rx_state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [15:0] rx_half;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_fall, rx_start_hit, rx_bit_end;
    logic        rx_done, rx_ferr_set;

    assign rx_fall      = rx_prev_q && !rx_s2_q;
    assign rx_half      = 16'(({1'b0, rx_div_q} + 17'd1) >> 1);
    assign rx_start_hit = (rx_half == 16'd0) || (rx_cnt_q >= rx_half - 16'd1);
    assign rx_bit_end   = (rx_cnt_q >= rx_div_q);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_fall) begin
                    rx_div_d   = div_q;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_start_hit) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_div_d   = div_q;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = 16'd0;
                    rx_div_d   = div_q;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d    = 16'd0;
                    rx_done     = rx_s2_q;
                    rx_ferr_set = !rx_s2_q;
                    rx_state_d  = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
        endcase
    end

    // A DATA read clears rx_valid before a byte completing in the same cycle is judged.
    always_comb begin
        div_d          = wr_div ? wdata : div_q;
        tx_ie_d        = wr_status ? wdata[ST_TX_IE] : tx_ie_q;
        rx_valid_d     = rx_valid_q && !rd_data;
        rx_overrun_d   = rx_overrun_q && !(wr_status && wdata[ST_RX_OVERRUN]);
        rx_frame_err_d = rx_frame_err_q && !(wr_status && wdata[ST_RX_FRAME_ERR]);
        rx_byte_d      = rx_byte_q;
        if (rx_done) begin
            if (rx_valid_d) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end
        if (rx_ferr_set) begin
            rx_frame_err_d = 1'b1;
        end
        irq_d = rx_valid_q || (tx_empty && tx_ie_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q          <= RESET_DIV;
            tx_ie_q        <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_byte_q      <= 8'h00;
            irq_q          <= 1'b0;
            tx_state_q     <= TX_IDLE;
            tx_cnt_q       <= 16'd0;
            tx_div_q       <= RESET_DIV;
            tx_bit_q       <= 3'd0;
            tx_shift_q     <= 8'h00;
            txd_q          <= 1'b1;
            rx_s1_q        <= 1'b1;
            rx_s2_q        <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= 16'd0;
            rx_div_q       <= RESET_DIV;
            rx_bit_q       <= 3'd0;
            rx_shift_q     <= 8'h00;
        end else begin
            div_q          <= div_d;
            tx_ie_q        <= tx_ie_d;
            rx_valid_q     <= rx_valid_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_byte_q      <= rx_byte_d;
            irq_q          <= irq_d;
            tx_state_q     <= tx_state_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_div_q       <= tx_div_d;
            tx_bit_q       <= tx_bit_d;
            tx_shift_q     <= tx_shift_d;
            txd_q          <= txd_d;
            rx_s1_q        <= rxd;
            rx_s2_q        <= rx_s1_q;
            rx_prev_q      <= rx_s2_q;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_div_q       <= rx_div_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
        end
    end

    logic [15:0] status;

    always_comb begin
        status                  = 16'h0000;
        status[ST_RX_VALID]     = rx_valid_q;
        status[ST_RX_OVERRUN]   = rx_overrun_q;
        status[ST_RX_FRAME_ERR] = rx_frame_err_q;
        status[ST_TX_FULL]      = fifo_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_TX_BUSY]      = (tx_state_q != TX_IDLE);
        status[ST_TX_IE]        = tx_ie_q;
        case (address[1:0])
            REG_DATA:   rdata = {8'h00, rx_byte_q};
            REG_STATUS: rdata = status;
            REG_DIV:    rdata = div_q;
            REG_RSVD:   rdata = 16'h0000;
        endcase
    end

    assign rdata_oe = rd_stb;
    assign txd      = txd_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_opc5_uart.sv
// Directed bench for opc5_uart at DIV=3 (4 clocks per bit) with a txd frame monitor.
module tb_opc5_uart;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        rnw;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdata_oe;
    logic        txd;
    logic        rxd;
    logic        irq;

    int         n_checks = 0;
    int         n_errors = 0;
    int         frames_seen = 0;
    int         lows;
    logic       mon_en = 1'b0;
    logic       exp_bit;
    logic [7:0] pat;
    logic [7:0] exp_q[$];

    opc5_uart #(
        .BASE_ADDR (16'hFE00),
        .TX_DEPTH  (4),
        .RESET_DIV (16'd3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .rnw      (rnw),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_oe (rdata_oe),
        .txd      (txd),
        .rxd      (rxd),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        rnw     = 1'b0;
        wdata   = d;
        @(posedge clk);
        #1;
        address = 16'h0000;
        rnw     = 1'b1;
        wdata   = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a;
        rnw     = 1'b1;
        #1 d = rdata;
        @(posedge clk);
        #1;
        address = 16'h0000;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] e);
        logic [15:0] d;
        bus_read(a, d);
        check(tag, d, e);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (4) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Decodes every frame seen on txd and checks it against exp_q.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                repeat (6) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = txd;
                    if (i < 7) repeat (4) @(negedge clk);
                end
                repeat (4) @(negedge clk);
                check("tx_stop_bit", txd, 1);
                frames_seen++;
                check("tx_frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("tx_frame_byte", b, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset   = 1'b1;
        address = 16'h0000;
        rnw     = 1'b1;
        wdata   = 16'h0000;
        rxd     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", txd, 1);
        check("reset_irq", irq, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_txd", txd, 1);
        check("post_reset_irq", irq, 0);
        read_check("reset_status", 16'hFE01, 16'h0010);
        read_check("reset_div", 16'hFE02, 16'h0003);
        read_check("reset_data", 16'hFE00, 16'h0000);
        read_check("reg3_read", 16'hFE03, 16'h0000);

        @(negedge clk);
        address = 16'hFE01;
        rnw     = 1'b1;
        #1 check("oe_read", rdata_oe, 1);
        rnw = 1'b0;
        #1 check("oe_write", rdata_oe, 0);
        address = 16'hFE05;
        rnw     = 1'b1;
        #1 check("oe_unselected", rdata_oe, 0);
        address = 16'h0000;

        bus_write(16'hFE02, 16'h1234);
        read_check("div_rw", 16'hFE02, 16'h1234);
        bus_write(16'hFE03, 16'hFFFF);
        read_check("reg3_write_ignored", 16'hFE03, 16'h0000);
        bus_write(16'hFE02, 16'h0003);
        bus_write(16'hFE06, 16'h0777);
        read_check("div_unselected_write", 16'hFE02, 16'h0003);

        // Single frame, bit-exact timing against the write edge.
        mon_en = 1'b1;
        pat    = 8'h55;
        exp_q.push_back(8'h55);
        bus_write(16'hFE00, 16'h0055);
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk);
            #1;
            if (k <= 4) exp_bit = 1'b0;
            else if (k <= 36) exp_bit = pat[(k - 5) / 4];
            else exp_bit = 1'b1;
            check("tx_single_bit", txd, exp_bit);
        end
        read_check("tx_empty_after_frame", 16'hFE01, 16'h0010);

        // Six back-to-back writes: one popped, four buffered, sixth dropped.
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h31 + 8'(i));
        for (int i = 0; i < 5; i++) bus_write(16'hFE00, 16'h0031 + 16'(i));
        bus_write(16'hFE00, 16'h00AA);
        read_check("fifo_full_status", 16'hFE01, 16'h0028);
        repeat (300) @(posedge clk);
        #1;
        check("fifo_frame_count", frames_seen, 6);
        check("fifo_exp_drained", exp_q.size(), 0);
        read_check("fifo_idle_status", 16'hFE01, 16'h0010);

        bus_write(16'hFE01, 16'h0040);
        repeat (2) @(posedge clk);
        #1;
        check("irq_tx_ie", irq, 1);
        read_check("tx_ie_status", 16'hFE01, 16'h0050);
        bus_write(16'hFE01, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("irq_tx_ie_off", irq, 0);

        // Receive, then overrun with an unread byte.
        send_rx(8'hC3, 1'b1);
        @(posedge clk);
        #1;
        check("irq_rx_valid", irq, 1);
        read_check("rx_status_valid", 16'hFE01, 16'h0011);
        send_rx(8'h11, 1'b1);
        read_check("rx_status_overrun", 16'hFE01, 16'h0013);
        read_check("rx_data_first", 16'hFE00, 16'h00C3);
        read_check("rx_status_after_read", 16'hFE01, 16'h0012);
        repeat (2) @(posedge clk);
        #1;
        check("irq_after_read", irq, 0);
        bus_write(16'hFE01, 16'h0002);
        read_check("overrun_cleared", 16'hFE01, 16'h0010);

        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        read_check("glitch_status", 16'hFE01, 16'h0010);

        send_rx(8'h5A, 1'b0);
        read_check("frame_err_status", 16'hFE01, 16'h0014);
        read_check("frame_err_byte_kept", 16'hFE00, 16'h00C3);
        bus_write(16'hFE01, 16'h0004);
        read_check("frame_err_cleared", 16'hFE01, 16'h0010);

        send_rx(8'hA5, 1'b1);
        read_check("rx_data_second", 16'hFE00, 16'h00A5);
        read_check("rx_status_final", 16'hFE01, 16'h0010);

        // Reset during data bit 3 of 8'h07 with a second byte queued.
        mon_en = 1'b0;
        bus_write(16'hFE00, 16'h0007);
        bus_write(16'hFE00, 16'h00F0);
        repeat (17) @(posedge clk);
        #1;
        check("mid_tx_bit3", txd, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_tx_txd", txd, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        read_check("reset_mid_tx_status", 16'hFE01, 16'h0010);
        lows = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1) lows++;
        end
        check("reset_mid_tx_quiet", lows, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
